fft_dif_stage1: RTL

- First radix-2 decimation-in-frequency stage of the 8-point FFT pipeline.
- Accepts one complex Q8.8 sample per cycle in natural order, x[0]..x[7].
- Produces sums A[n]=x[n]+x[n+4] and differences B[n]=x[n]-x[n+4] for n=0..3.
- The B stream feeds the downstream twiddle complex multiplier (W8^1..W8^3 path). The A stream goes to the next butterfly stage.

---
 rtl/fft_dif_stage1.sv | 123 ++++++++++++
 1 files changed

// File: rtl/fft_dif_stage1.sv
// First radix-2 DIF butterfly stage of an 8-point FFT: buffers x[0..3], emits
// A[n]=x[n]+x[n+4] as x[n+4] arrives, then drains B[n]=x[n]-x[n+4].
module fft_dif_stage1 #(
   parameter int SCALE = 0,
   parameter int DW    = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [DW-1:0] in_re,
   input  logic [DW-1:0] in_im,
   output logic          out_valid,
   output logic [DW-1:0] out_re,
   output logic [DW-1:0] out_im,
   output logic [2:0]    out_idx,
   output logic          out_last
);

   typedef enum logic [1:0] {FILL, BFLY, DRAIN} state_t;

   state_t state, state_nxt;
   logic [1:0] cnt;
   logic accept;

   logic signed [DW-1:0] buf_re [4];
   logic signed [DW-1:0] buf_im [4];
   logic signed [DW-1:0] diff_re [4];
   logic signed [DW-1:0] diff_im [4];

   logic signed [DW:0] sum_re, sum_im, dif_re, dif_im;

   // Reduce a DW+1 bit butterfly result back to DW bits: halve (floor) or clamp.
   function automatic logic signed [DW-1:0] fold(input logic signed [DW:0] v);
      if (SCALE != 0)
         fold = v[DW:1];
      else if (v[DW] != v[DW-1])
         fold = v[DW] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
      else
         fold = v[DW-1:0];
   endfunction

   assign sum_re = {buf_re[cnt][DW-1], buf_re[cnt]} + {in_re[DW-1], in_re};
   assign sum_im = {buf_im[cnt][DW-1], buf_im[cnt]} + {in_im[DW-1], in_im};
   assign dif_re = {buf_re[cnt][DW-1], buf_re[cnt]} - {in_re[DW-1], in_re};
   assign dif_im = {buf_im[cnt][DW-1], buf_im[cnt]} - {in_im[DW-1], in_im};

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= FILL;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         FILL:    if (accept && cnt == 2'd3) state_nxt = BFLY;
         BFLY:    if (accept && cnt == 2'd3) state_nxt = DRAIN;
         DRAIN:   if (cnt == 2'd3) state_nxt = FILL;
         default: state_nxt = FILL;
      endcase
   end

   always_comb begin
      in_ready = (state != DRAIN);
      accept   = in_valid & in_ready;
   end

   // One counter serves all three phases; it wraps 3->0 exactly at each phase change.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         cnt <= 2'd0;
      else if (accept || state == DRAIN)
         cnt <= cnt + 2'd1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 4; i++) begin
            buf_re[i]  <= '0;
            buf_im[i]  <= '0;
            diff_re[i] <= '0;
            diff_im[i] <= '0;
         end
      end else if (accept) begin
         if (state == FILL) begin
            buf_re[cnt] <= in_re;
            buf_im[cnt] <= in_im;
         end else if (state == BFLY) begin
            diff_re[cnt] <= fold(dif_re);
            diff_im[cnt] <= fold(dif_im);
         end
      end
   end

   // Output register: data/idx/last hold whenever nothing new is presented.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_re    <= '0;
         out_im    <= '0;
         out_idx   <= 3'd0;
         out_last  <= 1'b0;
      end else begin
         out_valid <= 1'b0;
         if (accept && state == BFLY) begin
            out_valid <= 1'b1;
            out_re    <= fold(sum_re);
            out_im    <= fold(sum_im);
            out_idx   <= {1'b0, cnt};
            out_last  <= 1'b0;
         end else if (state == DRAIN) begin
            out_valid <= 1'b1;
            out_re    <= diff_re[cnt];
            out_im    <= diff_im[cnt];
            out_idx   <= {1'b1, cnt};
            out_last  <= (cnt == 2'd3);
         end
      end
   end

endmodule
